// File: rtl/n_bit_adder_if.sv
// Operand/result bundle for one n_bit_adder cell: master drives operands, slave returns the registered sum.
interface n_bit_adder_if #(
  parameter int N = 16
);
  logic         in_valid;
  logic [N-1:0] input1;
  logic [N-1:0] input2;
  logic         cin;
  logic [N-1:0] out;
  logic         cout;
  logic         overflow;
  logic         out_valid;

  modport master (
    output in_valid, input1, input2, cin,
    input  out, cout, overflow, out_valid
  );

  modport slave (
    input  in_valid, input1, input2, cin,
    output out, cout, overflow, out_valid
  );
endinterface

// File: rtl/n_bit_adder.sv
// Ripple-carry two's-complement adder with registered sum/cout/overflow; N_BIT_ADDER_SATURATE_EN clamps out on overflow.
// Latency 1 cycle, one addition per cycle; no backpressure, out_valid is in_valid delayed by one edge.
module n_bit_adder #(
  parameter int N = 16
) (
  input  logic          clk,
  input  logic          reset,
  n_bit_adder_if.slave  bus
);

  if (N < 2) begin : g_bad_width
    $error("n_bit_adder: N must be at least 2");
  end

  logic [N:0]   c;
  logic [N-1:0] raw;
  logic [N-1:0] res;
  logic         ovf;

  logic [N-1:0] out_q;
  logic         cout_q;
  logic         ovf_q;
  logic         vld_q;

  assign c[0] = bus.cin;

  for (genvar i = 0; i < N; i++) begin : g_fa_cell
    logic p;
    assign p        = bus.input1[i] ^ bus.input2[i];
    assign raw[i]   = p ^ c[i];
    assign c[i+1]   = (bus.input1[i] & bus.input2[i]) | (c[i] & p);
  end

  // Carries into and out of the sign bit disagree exactly when the signed result cannot fit.
  assign ovf = c[N] ^ c[N-1];

  always_comb begin
    res = raw;
`ifdef N_BIT_ADDER_SATURATE_EN
    // Overflow only happens with equal operand signs, so operand A's sign picks the rail.
    if (ovf) begin
      res = bus.input1[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      out_q  <= res;
      cout_q <= c[N];
      ovf_q  <= ovf;
      vld_q  <= bus.in_valid;
    end
  end

  assign bus.out       = out_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_n_bit_adder.sv
// Self-checking bench for n_bit_adder: directed and randomized operands against an arithmetic model, plus a 16-node adder tree.
module tb_n_bit_adder;

`ifdef N_BIT_ADDER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  n_bit_adder_if #(.N(16)) bus ();

  n_bit_adder #(.N(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic c);
    res_t        r;
    int          full;
    logic [16:0] u;
    u     = {1'b0, a} + {1'b0, b} + {16'd0, c};
    full  = int'($signed(a)) + int'($signed(b)) + int'(c);
    r.cout = u[16];
    r.ovf  = (full > 32767) || (full < -32768);
    r.sum  = u[15:0];
    if (SAT && r.ovf) r.sum = (full > 0) ? 16'h7FFF : 16'h8000;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference pipeline: expectations for the next edge are formed from what the DUT samples.
  res_t exp_r;
  logic exp_v;
  bit   known;

  always @(posedge clk) begin
    if (reset) begin
      exp_r <= '0;
      exp_v <= 1'b0;
    end else begin
      exp_r <= model(bus.input1, bus.input2, bus.cin);
      exp_v <= bus.in_valid;
    end
    known <= 1'b1;
  end

  always @(negedge clk) begin
    if (known) begin
      check("stream_out",       {16'd0, bus.out},   {16'd0, exp_r.sum});
      check("stream_cout",      {31'd0, bus.cout},  {31'd0, exp_r.cout});
      check("stream_overflow",  {31'd0, bus.overflow}, {31'd0, exp_r.ovf});
      check("stream_out_valid", {31'd0, bus.out_valid}, {31'd0, exp_v});
    end
  end

  // Adder tree: nodes 0-7 add feature pairs, 8-14 reduce pairwise, 15 adds the last_in term.
  logic [15:0] na [16];
  logic [15:0] nb [16];
  logic [15:0] nq [16];
  logic        nvi [16];
  logic        nvq [16];
  logic [7:0]  feat [16];
  logic        tree_vld;

  always_comb begin
    for (int m = 0; m < 16; m++) begin
      na[m]  = '0;
      nb[m]  = '0;
      nvi[m] = 1'b0;
    end
    for (int m = 0; m < 8; m++) begin
      na[m]  = {{8{feat[2*m][7]}},   feat[2*m]};
      nb[m]  = {{8{feat[2*m+1][7]}}, feat[2*m+1]};
      nvi[m] = tree_vld;
    end
    for (int m = 8; m < 15; m++) begin
      na[m]  = nq[2*(m-8)];
      nb[m]  = nq[2*(m-8)+1];
      nvi[m] = nvq[2*(m-8)];
    end
    na[15]  = nq[14];
    nb[15]  = 16'd3;
    nvi[15] = nvq[14];
  end

  for (genvar k = 0; k < 16; k++) begin : g_node
    n_bit_adder_if #(.N(16)) nif ();
    assign nif.in_valid = nvi[k];
    assign nif.input1   = na[k];
    assign nif.input2   = nb[k];
    assign nif.cin      = 1'b0;
    assign nq[k]        = nif.out;
    assign nvq[k]       = nif.out_valid;
    n_bit_adder #(.N(16)) u_add (
      .clk   (clk),
      .reset (reset),
      .bus   (nif)
    );
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b, input logic c);
    bus.in_valid = v;
    bus.input1   = a;
    bus.input2   = b;
    bus.cin      = c;
  endtask

  task automatic expect_out(input string name, input logic [15:0] o, input logic co,
                            input logic ov, input logic v);
    check({name, "_out"},       {16'd0, bus.out},       {16'd0, o});
    check({name, "_cout"},      {31'd0, bus.cout},      {31'd0, co});
    check({name, "_overflow"},  {31'd0, bus.overflow},  {31'd0, ov});
    check({name, "_out_valid"}, {31'd0, bus.out_valid}, {31'd0, v});
  endtask

  res_t m;
  int   lat;

  initial begin
    tests    = 0;
    fails    = 0;
    known    = 1'b0;
    tree_vld = 1'b0;
    for (int i = 0; i < 16; i++) feat[i] = 8'd0;

    // Pin the reference model to hand-computed values.
    m = model(16'h7FFF, 16'h0001, 1'b0);
    check("model_pos_ovf", {15'd0, m}, {15'd0, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1});
    m = model(16'h8000, 16'hFFFF, 1'b0);
    check("model_neg_ovf", {15'd0, m}, {15'd0, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1});
    m = model(16'h0005, 16'hFFFA, 1'b1);
    check("model_cin_zero", {15'd0, m}, {15'd0, 16'h0000, 1'b1, 1'b0});

    reset = 1'b1;
    drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
    cyc();
    cyc();
    expect_out("reset", 16'h0000, 1'b0, 1'b0, 1'b0);

    reset = 1'b0;
    drive(1'b1, 16'h0003, 16'h0004, 1'b0);
    cyc();
    expect_out("first", 16'h0007, 1'b0, 1'b0, 1'b1);

    drive(1'b1, 16'hFFFF, 16'h000B, 1'b0);
    cyc();
    expect_out("sext_neg", 16'h000A, 1'b1, 1'b0, 1'b1);

    drive(1'b1, 16'h7FFF, 16'h0001, 1'b0);
    cyc();
    expect_out("pos_ovf", SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1, 1'b1);

    drive(1'b1, 16'h8000, 16'hFFFF, 1'b0);
    cyc();
    expect_out("neg_ovf", SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1, 1'b1);

    drive(1'b1, 16'h0005, 16'hFFFA, 1'b1);
    cyc();
    expect_out("cin_zero", 16'h0000, 1'b1, 1'b0, 1'b1);

    drive(1'b1, 16'd1, 16'd2, 1'b0);
    cyc();
    expect_out("b2b_a", 16'h0003, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 16'd10, 16'd10, 1'b0);
    cyc();
    expect_out("b2b_b", 16'h0014, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
    cyc();
    expect_out("b2b_c", 16'hFFFE, 1'b1, 1'b0, 1'b1);

    drive(1'b1, 16'd1, 16'd2, 1'b0);
    cyc();
    expect_out("rst_b2b_a", 16'h0003, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 16'd10, 16'd10, 1'b0);
    cyc();
    expect_out("rst_b2b_b", 16'h0014, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
    reset = 1'b1;
    cyc();
    expect_out("rst_b2b_c", 16'h0000, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    drive(1'b0, 16'd0, 16'd0, 1'b0);
    cyc();

    // Random traffic with occasional mid-stream resets; checked by the negedge compare process.
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 3))
        0:       drive(1'($urandom), 16'h7FFF - 16'($urandom_range(0, 3)),
                       16'($urandom_range(0, 3)), 1'($urandom));
        1:       drive(1'($urandom), 16'h8000 + 16'($urandom_range(0, 3)),
                       16'hFFFF - 16'($urandom_range(0, 3)), 1'($urandom));
        default: drive(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
      endcase
      reset = ($urandom_range(0, 31) == 0);
      cyc();
    end
    reset = 1'b0;
    drive(1'b0, 16'd0, 16'd0, 1'b0);
    cyc();
    cyc();
    cyc();
    cyc();
    cyc();
    cyc();

    // Eight -1 features and eight +11 features plus last_in 3 -> 83 after five levels.
    for (int i = 0; i < 16; i++) feat[i] = (i < 8) ? 8'hFF : 8'd11;
    tree_vld = 1'b1;
    cyc();
    for (int i = 0; i < 16; i++) feat[i] = 8'd0;
    tree_vld = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      if (lat == 0 && nvq[15] === 1'b1) begin
        lat = k;
        check("tree_sum", {16'd0, nq[15]}, 32'h0000_0053);
      end
      if (lat == 0) cyc();
    end
    if (lat == 0) begin
      tests++;
      fails++;
      $display("FAIL tree_timeout: root out_valid never rose, required within 10 cycles");
    end else begin
      check("tree_latency", 32'(lat), 32'd5);
    end
    cyc();
    check("tree_valid_drop", {31'd0, nvq[15]}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
